mem_responder: RTL and testbench
================================

# mem_responder

Slave-side responder for the pipeline core's data-memory interface: it answers the core's MEM-stage read/write requests from an internal word RAM and from a small memory-mapped timer. The timer drives the core's external `interrupter` input, closing the loop through CP0. It sits at the SoC top level between the core's data port and the rest of the board.

## Interface
- `RAM_WORDS`, 1024: data RAM depth in 32-bit words; power of two.
- `TIMER_BASE`, 32'hFFFF_0000: base byte address of the 16-byte timer register block.

- `clk`  in  1  main clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `mem_ren`  in  1  read request from the core (MEM stage).
- `mem_wen`  in  1  write request from the core (MEM stage).
- `mem_addr`  in  32  byte address; bits [1:0] ignored (word access only).
- `mem_dout`  in  32  write data from the core.
- `mem_din`  out  32  read data returned to the core.
- `interrupter`  out  1  level interrupt request to the core's CP0.
- `bus_err`  out  1  sticky flag: an access hit an unmapped address.

## Operation
- Decode, on `mem_addr`:
  - RAM hit: `mem_addr < RAM_WORDS*4`; word index is `mem_addr[log2(RAM_WORDS)+1:2]`.
  - Timer hit: `mem_addr[31:4] == TIMER_BASE[31:4]`; register index is `mem_addr[3:2]`.
  - Anything else is unmapped.
- RAM:
  - Asynchronous read.
  - Write is committed at the edge where `mem_wen=1`.
  - Contents are not cleared by `rst`.
- Timer registers:
  - 0x0 CTRL: bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD; other bits read 0.
  - 0x4 COUNT: read/write.
  - 0x8 COMPARE: read/write.
  - 0xC STATUS: bit0 PENDING, read-only except write-1-to-clear; other bits read 0.
- Counter, per edge in priority order:
  1. Core write to COUNT loads `mem_dout`.
  2. Otherwise, if EN and COUNT==COMPARE: COUNT becomes 0 when AUTO_RELOAD, else COUNT+1. Either way PENDING is set.
  3. Otherwise, if EN: COUNT+1, wrapping from 32'hFFFF_FFFF to 0.
  4. EN=0 holds COUNT.
- PENDING: a set event and a W1C in the same cycle leaves PENDING=1 (set wins). Writing 0 to STATUS has no effect.
- `interrupter` is a registered copy of `PENDING & IRQ_EN`. It stays high until the ISR clears PENDING or drops IRQ_EN.
- `mem_din`:
  - Combinational.
  - Holds RAM or register data when `mem_ren=1` and the address is mapped.
  - Is 0 when `mem_ren=0` or the address is unmapped.
- Unmapped accesses:
  - Writes are dropped.
  - Reads return 0.
  - Either one sets `bus_err`, which is cleared only by `rst`.
- `mem_ren` and `mem_wen` both high: the write is performed, and `mem_din` shows the pre-write value.

## Timing
- Read latency is 0 cycles: `mem_din` is valid in the same cycle as `mem_ren`. There is no stall or handshake; every request completes in one cycle.
- Writes are visible to reads in the next cycle.
- A COUNT read returns the registered value from before the current edge.
- A match at edge N sets PENDING at edge N, and `interrupter` rises at edge N+1.
- A W1C at edge M deasserts `interrupter` at edge M+1, unless the counter matches again.
- Reset values:
  - CTRL, COUNT, COMPARE, PENDING = 0.
  - `interrupter` = 0, `bus_err` = 0.
  - `mem_din` = 0 (`mem_ren` is 0 during reset).
- `rst` asserted while an interrupt is pending clears it at that edge.
- A RAM write in the reset cycle is still committed.

## Test plan
- RAM write/read: write 32'hDEAD_BEEF to 0x10, then read 0x10 → `mem_din`=32'hDEAD_BEEF. Read 0x13 → the same word.
- One-shot timer: COMPARE=5, COUNT=0, CTRL=3 at edge E → PENDING at edge E+6, `interrupter` high at E+7. COUNT reads 7 at E+7 and keeps counting.
- Auto-reload: COMPARE=3, CTRL=7 → COUNT sequence 0,1,2,3,0,1…; PENDING is set at each 3→0 step.
- W1C collision: issue the STATUS write 1 in the same cycle as a match → PENDING stays 1. A later W1C with no match → `interrupter` low one edge later.
- Unmapped access: read 0x8000_0000 → `mem_din`=0 and `bus_err`=1. RAM contents are unchanged by a write there.
- Reset mid-operation: assert `rst` with the timer running and `interrupter`=1 → all registers 0 and `interrupter`=0 at the next edge. RAM data written earlier is still readable.

Source files
------------

// File: rtl/mem_responder.sv
// Data-memory slave for the pipeline core: word RAM plus a memory-mapped
// compare timer whose pending flag drives the core's interrupter input.
module mem_responder #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter logic [31:0] TIMER_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        interrupter,
    output logic        bus_err
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COUNT   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;

    logic [31:0]   ram [RAM_WORDS];
    logic          ram_hit;
    logic          tmr_hit;
    logic          unmapped;
    logic [AW-1:0] ram_idx;
    reg_sel_e      reg_sel;

    logic          ram_we;
    logic          ctrl_we;
    logic          count_we;
    logic          compare_we;
    logic          status_we;

    logic          en;
    logic          irq_en;
    logic          auto_rld;
    logic [31:0]   count;
    logic [31:0]   count_nxt;
    logic [31:0]   compare;
    logic          pending;
    logic          cnt_match;
    logic          pend_set;
    logic          pend_clr;

    logic          unused_addr_bits;

    // RAM decode wins if a badly chosen TIMER_BASE ever overlaps it.
    assign ram_hit  = {1'b0, mem_addr} < RAM_BYTES;
    assign tmr_hit  = !ram_hit && (mem_addr[31:4] == TIMER_BASE[31:4]);
    assign unmapped = !ram_hit && !tmr_hit;
    assign ram_idx  = mem_addr[AW+1:2];
    assign reg_sel  = reg_sel_e'(mem_addr[3:2]);

    assign unused_addr_bits = ^mem_addr[1:0];

    assign ram_we     = mem_wen && ram_hit;
    assign ctrl_we    = mem_wen && tmr_hit && (reg_sel == REG_CTRL);
    assign count_we   = mem_wen && tmr_hit && (reg_sel == REG_COUNT);
    assign compare_we = mem_wen && tmr_hit && (reg_sel == REG_COMPARE);
    assign status_we  = mem_wen && tmr_hit && (reg_sel == REG_STATUS);

    // RAM has no reset so a write in the reset cycle still lands.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= mem_dout;
        end
    end

    assign cnt_match = en && (count == compare);
    assign pend_set  = cnt_match && !count_we;
    assign pend_clr  = status_we && mem_dout[0];

    always_comb begin
        count_nxt = count;
        if (count_we) begin
            count_nxt = mem_dout;
        end else if (cnt_match) begin
            count_nxt = auto_rld ? 32'd0 : count + 32'd1;
        end else if (en) begin
            count_nxt = count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en          <= 1'b0;
            irq_en      <= 1'b0;
            auto_rld    <= 1'b0;
            count       <= 32'd0;
            compare     <= 32'd0;
            pending     <= 1'b0;
            interrupter <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            if (ctrl_we) begin
                {auto_rld, irq_en, en} <= mem_dout[2:0];
            end
            if (compare_we) begin
                compare <= mem_dout;
            end
            count <= count_nxt;
            // A set event in the same cycle as a W1C keeps the flag.
            if (pend_set) begin
                pending <= 1'b1;
            end else if (pend_clr) begin
                pending <= 1'b0;
            end
            interrupter <= pending && irq_en;
            if ((mem_ren || mem_wen) && unmapped) begin
                bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_din = 32'd0;
        if (mem_ren) begin
            if (ram_hit) begin
                mem_din = ram[ram_idx];
            end else if (tmr_hit) begin
                unique case (reg_sel)
                    REG_CTRL:    mem_din = {29'd0, auto_rld, irq_en, en};
                    REG_COUNT:   mem_din = count;
                    REG_COMPARE: mem_din = compare;
                    REG_STATUS:  mem_din = {31'd0, pending};
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios followed by
// random traffic, all checked against a cycle-level reference model.
module tb_mem_responder;

    localparam logic [31:0] TB = 32'hFFFF_0000;

    logic        clk;
    logic        rst;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        interrupter;
    logic        bus_err;

    int n_chk;
    int n_fail;
    logic [31:0] rd_val;

    logic [31:0] m_ram [1024];
    bit          m_vld [1024];
    logic        m_en;
    logic        m_ie;
    logic        m_ar;
    logic [31:0] m_count;
    logic [31:0] m_cmp;
    logic        m_pend;
    logic        m_irq;
    logic        m_berr;

    mem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .mem_ren     (mem_ren),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_dout    (mem_dout),
        .mem_din     (mem_din),
        .interrupter (interrupter),
        .bus_err     (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic is_ram(input logic [31:0] a);
        return a < 32'd4096;
    endfunction

    function automatic logic is_tmr(input logic [31:0] a);
        return !is_ram(a) && (a[31:4] == TB[31:4]);
    endfunction

    function automatic logic mdl_known(input logic [31:0] a);
        if (is_ram(a)) return m_vld[a[11:2]];
        return 1'b1;
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        if (is_ram(a)) return m_ram[a[11:2]];
        if (!is_tmr(a)) return 32'd0;
        case (a[3:2])
            2'd0:    return {29'd0, m_ar, m_ie, m_en};
            2'd1:    return m_count;
            2'd2:    return m_cmp;
            default: return {31'd0, m_pend};
        endcase
    endfunction

    task automatic mdl_step(input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic rs);
        logic match;
        logic wc;
        logic th;
        th = is_tmr(a);
        if (w && is_ram(a)) begin
            m_ram[a[11:2]] = d;
            m_vld[a[11:2]] = 1'b1;
        end
        if (rs) begin
            {m_en, m_ie, m_ar, m_pend, m_irq, m_berr} = '0;
            m_count = 32'd0;
            m_cmp   = 32'd0;
        end else begin
            match = m_en && (m_count == m_cmp);
            wc    = w && th && (a[3:2] == 2'd1);
            m_irq = m_pend && m_ie;
            if (wc) m_count = d;
            else if (match) m_count = m_ar ? 32'd0 : m_count + 32'd1;
            else if (m_en) m_count = m_count + 32'd1;
            if (match && !wc) m_pend = 1'b1;
            else if (w && th && a[3:2] == 2'd3 && d[0]) m_pend = 1'b0;
            if (w && th && a[3:2] == 2'd0) {m_ar, m_ie, m_en} = d[2:0];
            if (w && th && a[3:2] == 2'd2) m_cmp = d;
            if ((r || w) && !is_ram(a) && !th) m_berr = 1'b1;
        end
    endtask

    task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic rs);
        mem_ren  = r;
        mem_wen  = w;
        mem_addr = a;
        mem_dout = d;
        rst      = rs;
        #2;
        rd_val = mem_din;
        if (!r || mdl_known(a))
            check("din", mem_din, r ? mdl_rd(a) : 32'd0);
        @(posedge clk);
        mdl_step(r, w, a, d, rs);
        #1;
        check("irq", {31'd0, interrupter}, {31'd0, m_irq});
        check("bus_err", {31'd0, bus_err}, {31'd0, m_berr});
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, a, d, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b1, 1'b0, a, 32'd0, 1'b0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        {m_en, m_ie, m_ar, m_pend, m_irq, m_berr} = '0;
        m_count  = 32'd0;
        m_cmp    = 32'd0;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
        mem_addr = 32'd0;
        mem_dout = 32'd0;
        rst      = 1'b1;

        cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            rd(TB | 32'(i << 2));
            check("rst_reg", rd_val, 32'd0);
        end

        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10);
        check("ram_rd", rd_val, 32'hDEAD_BEEF);
        rd(32'h13);
        check("ram_rd_lsb", rd_val, 32'hDEAD_BEEF);
        wr(32'hFFC, 32'hA5A5_0001);
        rd(32'hFFC);
        check("ram_last", rd_val, 32'hA5A5_0001);

        // one-shot: CTRL write is edge E
        wr(TB + 8, 32'd5);
        wr(TB + 4, 32'd0);
        wr(TB, 32'd3);
        repeat (5) idle();
        rd(TB + 12);
        check("pend_e6", rd_val, 32'd0);
        rd(TB + 12);
        check("pend_e7", rd_val, 32'd1);
        check("irq_e7", {31'd0, interrupter}, 32'd1);
        rd(TB + 4);
        check("count_e7", rd_val, 32'd7);
        wr(TB + 12, 32'd1);
        check("irq_w1c_m", {31'd0, interrupter}, 32'd1);
        idle();
        check("irq_w1c_m1", {31'd0, interrupter}, 32'd0);

        // auto-reload
        wr(TB, 32'd0);
        wr(TB + 8, 32'd3);
        wr(TB + 4, 32'd0);
        wr(TB, 32'd7);
        for (int i = 0; i < 8; i++) begin
            rd(TB + 4);
            check("ar_seq", rd_val, 32'(i % 4));
        end
        wr(TB + 12, 32'd1);
        rd(TB + 12);
        check("pend_clr", rd_val, 32'd0);
        idle();
        wr(TB + 12, 32'd1);
        rd(TB + 12);
        check("w1c_coll", rd_val, 32'd1);
        wr(TB + 12, 32'd1);
        check("irq_late_w1c", {31'd0, interrupter}, 32'd1);
        idle();
        check("irq_late_low", {31'd0, interrupter}, 32'd0);
        wr(TB, 32'd0);
        wr(TB + 12, 32'd1);

        // counter wrap
        wr(TB + 4, 32'hFFFF_FFFF);
        wr(TB, 32'd1);
        rd(TB + 4);
        check("wrap_pre", rd_val, 32'hFFFF_FFFF);
        rd(TB + 4);
        check("wrap_post", rd_val, 32'd0);
        wr(TB, 32'd0);

        // unmapped
        rd(32'h8000_0000);
        check("unm_rd", rd_val, 32'd0);
        check("unm_berr", {31'd0, bus_err}, 32'd1);
        wr(32'h8000_0000, 32'h1234_5678);
        rd(32'h10);
        check("unm_ram", rd_val, 32'hDEAD_BEEF);
        rd(32'h1000);
        check("unm_4k", rd_val, 32'd0);
        rd(TB + 16);
        check("unm_tb16", rd_val, 32'd0);

        // reset mid-operation, with a RAM write in the reset cycle
        wr(TB + 12, 32'd1);
        wr(TB + 8, 32'd2);
        wr(TB + 4, 32'd0);
        wr(TB, 32'd3);
        repeat (5) idle();
        check("irq_pre_rst", {31'd0, interrupter}, 32'd1);
        cyc(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b1);
        check("irq_rst", {31'd0, interrupter}, 32'd0);
        check("berr_rst", {31'd0, bus_err}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd(TB | 32'(i << 2));
            check("post_rst_reg", rd_val, 32'd0);
        end
        rd(32'h10);
        check("ram_keep", rd_val, 32'hDEAD_BEEF);
        rd(32'h20);
        check("ram_rst_wr", rd_val, 32'hCAFE_F00D);

        for (int i = 0; i < 3000; i++) begin
            int unsigned sel;
            logic [31:0] a;
            logic [31:0] d;
            logic r;
            logic w;
            logic rs;
            sel = $urandom_range(0, 15);
            if (sel < 8) begin
                a = 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
            end else if (sel == 8) begin
                a = 32'hFFC | 32'($urandom_range(0, 3));
            end else if (sel < 15) begin
                a = TB | 32'($urandom_range(0, 3) << 2) | 32'($urandom_range(0, 3));
            end else begin
                case ($urandom_range(0, 3))
                    0:       a = 32'h0000_1000;
                    1:       a = 32'h8000_0000;
                    2:       a = TB + 32'd16;
                    default: a = TB - 32'd4;
                endcase
            end
            if ($urandom_range(0, 31) == 0) d = 32'hFFFF_FFFE;
            else if ($urandom_range(0, 3) == 0) d = $urandom;
            else d = 32'($urandom_range(0, 12));
            r  = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 199) == 0);
            cyc(r, w, a, d, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
